// File: rtl/signed_resize_pkg.sv
// Shared opcodes and saturation bounds for the signed resize datapath.
package signed_resize_pkg;

    typedef enum logic [1:0] {
        OP_SEXT8 = 2'b00,
        OP_ZEXT8 = 2'b01,
        OP_SAT8  = 2'b10,
        OP_PASS  = 2'b11
    } op_e;

    localparam logic signed [15:0] SAT_MAX = 16'sh007F;
    localparam logic signed [15:0] SAT_MIN = 16'shFF80;

endpackage

// File: rtl/signed_resize_unit.sv
// Combinational 16-bit resize: sign/zero-extend low byte, saturate to int8, or pass.
// Zero latency; no handshake of its own.
module signed_resize_unit
    import signed_resize_pkg::*;
(
    input  logic [15:0] i_d,
    input  logic [1:0]  i_op,
    output logic [15:0] o_result,
    output logic        o_ovf
);

    always_comb begin
        o_result = i_d;
        o_ovf    = 1'b0;
        case (i_op)
            OP_SEXT8: o_result = {{8{i_d[7]}}, i_d[7:0]};
            OP_ZEXT8: o_result = {8'h00, i_d[7:0]};
            OP_SAT8: begin
                // In-range values are already their own 16-bit sign extension.
                if ($signed(i_d) > SAT_MAX) begin
                    o_result = SAT_MAX;
                    o_ovf    = 1'b1;
                end else if ($signed(i_d) < SAT_MIN) begin
                    o_result = SAT_MIN;
                    o_ovf    = 1'b1;
                end
            end
            default: o_result = i_d;
        endcase
    end

endmodule

// File: rtl/signed_resize_arbiter.sv
// Round-robin share of one resize unit among NUM_REQ requesters; 1-cycle registered result.
// Stalls all requesters while a result is held unconsumed. Optional SIGNED_RESIZE_STATS_EN adds sat_count.
module signed_resize_arbiter
    import signed_resize_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]  req_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_ovf
`ifdef SIGNED_RESIZE_STATS_EN
    ,
    output logic [15:0]           sat_count
`endif
);

    localparam int              LAST     = NUM_REQ - 1;
    localparam int              ONE      = 1;
    localparam logic [ID_W-1:0] LAST_IDX = LAST[ID_W-1:0];
    localparam logic [ID_W-1:0] ONE_IDX  = ONE[ID_W-1:0];

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_out_valid;
    logic [15:0]        r_out_data;
    logic [ID_W-1:0]    r_out_id;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_any;
    logic               w_hi_any;
    logic [ID_W-1:0]    w_hi_idx;
    logic [ID_W-1:0]    w_lo_idx;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic [15:0]        w_sel_d;
    logic [1:0]         w_sel_op;
    logic [15:0]        w_result;
    logic               w_ovf;
    logic               w_xfer;
    logic [ID_W-1:0]    w_next_ptr;

    assign w_accept = !r_out_valid || out_ready;

    // Descending scan leaves the lowest valid index at/above rr_ptr in w_hi_idx,
    // and the lowest valid index overall in w_lo_idx for the wrap-around case.
    always_comb begin
        w_any    = 1'b0;
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any    = 1'b1;
                w_lo_idx = i[ID_W-1:0];
                if (i[ID_W-1:0] >= r_rr_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = i[ID_W-1:0];
                end
            end
        end
        w_gnt_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_grant  = '0;
        w_sel_d  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i[ID_W-1:0] == w_gnt_idx) begin
                w_grant[i] = w_any;
                w_sel_d    = req_data[i*16 +: 16];
                w_sel_op   = req_op[i*2 +: 2];
            end
        end
    end

    assign req_ready  = w_accept ? w_grant : '0;
    assign w_xfer     = w_accept && w_any;
    assign w_next_ptr = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + ONE_IDX;

    signed_resize_unit u_unit (
        .i_d      (w_sel_d),
        .i_op     (w_sel_op),
        .o_result (w_result),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_xfer) begin
            r_rr_ptr    <= w_next_ptr;
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_id    <= w_gnt_idx;
            r_out_ovf   <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_ovf   = r_out_ovf;

`ifdef SIGNED_RESIZE_STATS_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (w_xfer && w_ovf && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_signed_resize_arbiter.sv
// Directed self-checking bench for signed_resize_arbiter (4 requesters).
module tb_signed_resize_arbiter;
    import signed_resize_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_data;
    logic [7:0]  req_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_id;
    logic        out_ovf;
`ifdef SIGNED_RESIZE_STATS_EN
    logic [15:0] sat_count;
`endif

    int total;
    int bad;

    signed_resize_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_op    (req_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ovf   (out_ovf)
`ifdef SIGNED_RESIZE_STATS_EN
        ,
        .sat_count (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [15:0] d, input logic [1:0] op);
        req_data[i*16 +: 16] = d;
        req_op[i*2 +: 2]     = op;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_op = '0; out_ready = 1'b1;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        total++; if (out_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", out_id); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
`ifdef SIGNED_RESIZE_STATS_EN
        total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL reset_satcnt got=%0d exp=0", sat_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One requester at a time, rr_ptr walks 0->1->2->3->0.
    task automatic test_ops();
        int          idx [0:3];
        logic [1:0]  op  [0:3];
        logic [15:0] din [0:3];
        logic [15:0] exp [0:3];
        idx = '{0, 1, 2, 3};
        op  = '{OP_SEXT8, OP_ZEXT8, OP_SEXT8, OP_PASS};
        din = '{16'h0080, 16'h12F0, 16'hAB7F, 16'hBEEF};
        exp = '{16'hFF80, 16'h00F0, 16'h007F, 16'hBEEF};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = '0;
            req_valid[idx[k]] = 1'b1;
            set_req(idx[k], din[k], op[k]);
            @(negedge clk);
            total++; if (req_ready !== req_valid) begin bad++; $display("FAIL ops_ready[%0d] got=%b exp=%b", k, req_ready, req_valid); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ops_valid[%0d] got=%b exp=1", k, out_valid); end
            total++; if (out_data !== exp[k]) begin bad++; $display("FAIL ops_data[%0d] got=%h exp=%h", k, out_data, exp[k]); end
            total++; if (out_id !== 2'(idx[k])) begin bad++; $display("FAIL ops_id[%0d] got=%0d exp=%0d", k, out_id, idx[k]); end
            total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL ops_ovf[%0d] got=%b exp=0", k, out_ovf); end
        end
        req_valid = '0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_idle_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'hBEEF) begin bad++; $display("FAIL ops_idle_hold got=%h exp=beef", out_data); end
    endtask

    // Requester 1 held valid, operand changes every cycle.
    task automatic test_sat();
        logic [15:0] din [0:5];
        logic [15:0] exp [0:5];
        logic        ovf [0:5];
        din = '{16'h0200, 16'hFE00, 16'h0005, 16'h0080, 16'hFF80, 16'h007F};
        exp = '{16'h007F, 16'hFF80, 16'h0005, 16'h007F, 16'hFF80, 16'h007F};
        ovf = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            set_req(1, din[k], OP_SAT8);
            @(posedge clk); #1;
            total++; if (out_data !== exp[k]) begin bad++; $display("FAIL sat_data[%0d] got=%h exp=%h", k, out_data, exp[k]); end
            total++; if (out_ovf !== ovf[k]) begin bad++; $display("FAIL sat_ovf[%0d] got=%b exp=%b", k, out_ovf, ovf[k]); end
            total++; if (out_id !== 2'd1) begin bad++; $display("FAIL sat_id[%0d] got=%0d exp=1", k, out_id); end
        end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'h1000 + 16'(i), OP_PASS);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++; if (req_ready !== (4'b0001 << (k % 4))) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4)); end
            @(posedge clk); #1;
            total++; if (out_id !== 2'(k % 4)) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, out_id, k % 4); end
            total++; if (out_data !== 16'h1000 + 16'(k % 4)) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, out_data, 16'h1000 + 16'(k % 4)); end
        end
    endtask

    // Continues from round robin: out_id=1 held, rr_ptr=2.
    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 16'h1001) begin
                bad++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/1/1001", k, out_valid, out_id, out_data);
            end
        end
        out_ready = 1'b1;
        for (int k = 2; k < 4; k++) begin
            @(negedge clk);
            total++; if (req_ready !== (4'b0001 << k)) begin bad++; $display("FAIL bp_resume_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << k); end
            @(posedge clk); #1;
            total++; if (out_id !== 2'(k)) begin bad++; $display("FAIL bp_resume_id[%0d] got=%0d exp=%0d", k, out_id, k); end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0010;
        set_req(1, 16'h00AA, OP_PASS);
        set_req(3, 16'h00BB, OP_PASS);
        @(posedge clk); #1;
        total++; if (out_id !== 2'd1 || out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%0d/%b exp=1/1", out_id, out_valid); end
        req_valid = '0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_async_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rm_async_data got=%h exp=0000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rm_first_ready got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        total++; if (out_id !== 2'd1 || out_data !== 16'h00AA) begin bad++; $display("FAIL rm_first got=%0d/%h exp=1/00aa", out_id, out_data); end
        @(posedge clk); #1;
        total++; if (out_id !== 2'd3 || out_data !== 16'h00BB) begin bad++; $display("FAIL rm_second got=%0d/%h exp=3/00bb", out_id, out_data); end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

`ifdef SIGNED_RESIZE_STATS_EN
    task automatic test_stats();
        logic [15:0] din [0:5];
        logic [1:0]  op  [0:5];
        din = '{16'h0200, 16'h8000, 16'h0100, 16'h0010, 16'h1234, 16'hFFFF};
        op  = '{OP_SAT8, OP_SAT8, OP_SAT8, OP_SAT8, OP_PASS, OP_PASS};
        apply_reset();
        total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL stats_clear got=%0d exp=0", sat_count); end
        out_ready = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            set_req(0, din[k], op[k]);
            @(posedge clk); #1;
        end
        req_valid = '0;
        total++; if (sat_count !== 16'd3) begin bad++; $display("FAIL stats_count got=%0d exp=3", sat_count); end
        total++; if (out_ovf !== 1'b0 || out_data !== 16'hFFFF) begin bad++; $display("FAIL stats_last got=%b/%h exp=0/ffff", out_ovf, out_data); end
        @(posedge clk); #1;
        total++; if (sat_count !== 16'd3) begin bad++; $display("FAIL stats_hold got=%0d exp=3", sat_count); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ops();
        test_sat();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef SIGNED_RESIZE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signed_resize_arbiter.md
# signed_resize_arbiter

Round-robin scheduler that shares one signed resize datapath among NUM_REQ requesters. The datapath does sign-extend, zero-extend, saturate and pass. Each requester presents a 16-bit operand and a 2-bit opcode over a valid/ready handshake. The winner's result is registered and presented downstream with the requester ID. The block sits between the arithmetic front-ends and the result bus wherever width conversion is needed.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of out_id; must satisfy 2^ID_W >= NUM_REQ
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (combinational)
- req_data  in  NUM_REQ*16  operand; requester i in bits [16i+15:16i]
- req_op  in  NUM_REQ*2  opcode; requester i in bits [2i+1:2i]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  16  resized result
- out_id  out  ID_W  index of the requester that produced out_data
- out_ovf  out  1  SAT8 clipped this result
- sat_count  out  16  clipped-result counter; present only with SIGNED_RESIZE_STATS_EN

## Operation
- Opcodes:
  - 00 SEXT8: {{8{d[7]}}, d[7:0]}.
  - 01 ZEXT8: {8'h00, d[7:0]}.
  - 10 SAT8: treat d as signed 16; clamp to [-128, 127]; sign-extend to 16 bits.
  - 11 PASS: d.
- out_ovf = 1 only for SAT8 when clamping occurred; 0 for every other opcode.
- Accept condition: accept = !out_valid || out_ready.
- Grant: the lowest index i with req_valid[i], searched cyclically from rr_ptr (rr_ptr, rr_ptr+1, …, wrapping at NUM_REQ-1 → 0).
- req_ready[i] = accept && grant[i]. At most one bit of req_ready is high.
- Transfer on req_valid[i] && req_ready[i]:
  - out_data, out_id and out_ovf load from requester i.
  - out_valid sets.
  - rr_ptr ← (i+1) mod NUM_REQ.
- No request valid while accept is high: out_valid clears if out_ready was high; rr_ptr holds.
- Stall (out_valid && !out_ready):
  - req_ready is all zero.
  - Output registers and rr_ptr hold.
- Requesters hold req_data and req_op stable while req_valid is high without req_ready. req_valid may drop only after a transfer.
- out_data is undefined-free: it always holds the last loaded value.

## Timing
- Latency: 1 cycle from request transfer to out_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- Reset (asynchronous, immediate): out_valid=0, out_data=16'h0000, out_id=0, out_ovf=0, rr_ptr=0, sat_count=0.
- Reset asserted mid-operation discards the pending result. The first grant after reset searches from index 0.
- Same-cycle downstream consume and new grant: the new result replaces the old one with no bubble.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 transfers.

## Configuration
- SIGNED_RESIZE_STATS_EN defined:
  - sat_count port exists.
  - sat_count increments on every transfer whose opcode is SAT8 and clips.
  - It saturates at 16'hFFFF and never wraps.
  - Reset clears it.
- SIGNED_RESIZE_STATS_EN undefined: sat_count port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package signed_resize_pkg holds:
  - opcode constants OP_SEXT8, OP_ZEXT8, OP_SAT8, OP_PASS;
  - SAT_MAX = 16'sh007F and SAT_MIN = 16'shFF80.
- Sub-module signed_resize_unit: purely combinational (d, op) → (result, ovf). It is instantiated once, fed by a mux selected by the grant.
- The top level owns the round-robin pointer, grant logic, output register and optional counter.

## Test plan
- Req 0, SEXT8, d=16'h0080, out_ready=1 → next cycle out_valid=1, out_data=16'hFF80, out_id=0, out_ovf=0.
- SAT8 on three operands, all via one requester:
  - d=16'h0200 → out_data=16'h007F, out_ovf=1.
  - d=16'hFE00 → out_data=16'hFF80, out_ovf=1.
  - d=16'h0005 → out_data=16'h0005, out_ovf=0.
- All four requesters valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1 on consecutive cycles. Exactly one req_ready high each cycle.
- Backpressure: hold out_ready=0 for 3 cycles with all requesters valid → out_data/out_id unchanged and req_ready=0 throughout. On release, grant resumes at the stored rr_ptr.
- Reset asserted while out_valid=1 and rr_ptr=2 → out_valid=0 immediately. After release, requesters 1 and 3 valid → first out_id=1.
- With SIGNED_RESIZE_STATS_EN: 3 clipping SAT8 transfers, 1 non-clipping SAT8, 2 PASS → sat_count=3.
